// File: rtl/equ_serial_arb.sv
// rtl/equ_serial_arb.sv - round-robin shared bit-serial equality engine for two requesters
// Optional early exit on first mismatching bit: define EQU_SERIAL_EARLY_EXIT_EN.
module equ_serial_arb #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             gnt1,
  output logic             bit_x,
  output logic             bit_y,
  input  logic             bit_eq,
  output logic [IDX_W-1:0] bit_idx,
  output logic             busy,
  output logic             done,
  output logic             r,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE, GRANT, CMP, DONE} state_t;

  state_t           state;
  logic             last_owner;
  logic             acc;
  logic [WIDTH-1:0] sx;
  logic [WIDTH-1:0] sy;
  logic             pick;
  logic             acc_next;
  logic             last_bit;
  logic             stop;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = ~last_owner;
    else if (req1)    pick = 1'b1;
  end

  assign op_x     = owner ? x1 : x0;
  assign op_y     = owner ? y1 : y0;
  assign acc_next = acc & bit_eq;
  assign last_bit = (bit_idx == IDX_W'(WIDTH - 1));

`ifdef EQU_SERIAL_EARLY_EXIT_EN
  assign stop = last_bit | ~bit_eq;
`else
  assign stop = last_bit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r          <= 1'b0;
      owner      <= 1'b0;
      bit_idx    <= '0;
      bit_x      <= 1'b0;
      bit_y      <= 1'b0;
      last_owner <= 1'b1;
      acc        <= 1'b1;
      sx         <= '0;
      sy         <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req0 || req1) begin
            state <= GRANT;
            owner <= pick;
            gnt0  <= ~pick;
            gnt1  <= pick;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          // Operands are sampled at the end of the grant cycle; bit 0 goes out immediately.
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          bit_x   <= op_x[0];
          bit_y   <= op_y[0];
          sx      <= op_x >> 1;
          sy      <= op_y >> 1;
          acc     <= 1'b1;
          bit_idx <= '0;
          state   <= CMP;
        end
        CMP: begin
          acc <= acc_next;
          if (stop) begin
            state <= DONE;
            done  <= 1'b1;
            r     <= acc_next;
            bit_x <= 1'b0;
            bit_y <= 1'b0;
          end else begin
            bit_x <= sx[0];
            bit_y <= sy[0];
            sx    <= sx >> 1;
            sy    <= sy >> 1;
            if (!last_bit) bit_idx <= bit_idx + 1'b1;
          end
        end
        DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_equ_serial_arb.sv
// tb/tb_equ_serial_arb.sv - scoreboard bench for equ_serial_arb
module tb_equ_serial_arb;
  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic             gnt0, gnt1, bit_x, bit_y, bit_eq, busy, done, r, owner;
  logic [IDX_W-1:0] bit_idx;

  typedef struct {
    logic owner;
    logic r;
    int   req_cyc;
    int   lat;
    bit   lat_valid;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  equ_serial_arb #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .x0(x0), .y0(y0), .gnt0(gnt0),
    .req1(req1), .x1(x1), .y1(y1), .gnt1(gnt1),
    .bit_x(bit_x), .bit_y(bit_y), .bit_eq(bit_eq), .bit_idx(bit_idx),
    .busy(busy), .done(done), .r(r), .owner(owner)
  );

  // shared equ_1bit cell
  assign bit_eq = ~(bit_x ^ bit_y);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef EQU_SERIAL_EARLY_EXIT_EN
    for (int k = 0; k < WIDTH; k++)
      if (x[k] != y[k]) return 3 + k;
`endif
    return WIDTH + 2;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("r", r, e.r);
        check("owner", owner, e.owner);
        if (e.lat_valid) check("latency", cyc - e.req_cyc, e.lat);
      end
    end
  end

  task automatic run_op(input bit n, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    bit   seen;
    int   j;
    @(negedge clk);
    if (n) begin req1 = 1'b1; x1 = x; y1 = y; end
    else   begin req0 = 1'b1; x0 = x; y0 = y; end
    e.owner = n; e.r = (x == y); e.req_cyc = cyc; e.lat = exp_lat(x, y); e.lat_valid = 1'b1;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) seen = 1'b1;
    end
    check("gnt_seen", seen, 1);
    check("gnt_who", {gnt1, gnt0}, n ? 2 : 1);
    req0 = 1'b0;
    req1 = 1'b0;
    j = 0;
    seen = 1'b0;
    for (int i = 0; i < WIDTH + 6 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) check("gnt_pulse", gnt0 | gnt1, 0);
      if (done) seen = 1'b1;
      else if (busy && j < WIDTH) begin
        check("bit_idx", bit_idx, j);
        check("bit_x", bit_x, x[j]);
        check("bit_y", bit_y, y[j]);
        j++;
      end
    end
    check("done_seen", seen, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   dones;
    bit   hit;
    bit   exp_g;
    exp_t e;
    logic [WIDTH-1:0] rx, ry;

    repeat (3) @(negedge clk);
    check("rst_gnt", {gnt1, gnt0}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_r", r, 0);
    check("rst_owner", owner, 0);
    check("rst_bit_idx", bit_idx, 0);
    check("rst_bits", {bit_x, bit_y}, 0);
    rst_n = 1'b1;

    run_op(1'b0, 8'h5A, 8'h5A);
    run_op(1'b1, 8'h80, 8'h00);
    run_op(1'b0, 8'hFF, 8'hFE);
    run_op(1'b1, 8'h00, 8'h00);

    // reset in the middle of a compare
    @(negedge clk);
    req0 = 1'b1; x0 = 8'h0F; y0 = 8'h0F;
    e.owner = 1'b0; e.r = 1'b1; e.req_cyc = cyc; e.lat = WIDTH + 2; e.lat_valid = 1'b1;
    sb.push_back(e);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      if (busy && !gnt0 && bit_idx == 3'd4) hit = 1'b1;
    end
    check("mid_cmp_reached", hit, 1);
    rst_n = 1'b0;
    req0 = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mrst_gnt", {gnt1, gnt0}, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_r_owner", {r, owner}, 0);
    check("mrst_bit_idx", bit_idx, 0);
    check("mrst_bits", {bit_x, bit_y}, 0);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mrst_no_done", dones, 0);
    run_op(1'b0, 8'h33, 8'h33);

    for (int i = 0; i < 1000; i++) begin
      rx = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       ry = rx;
        1:       ry = rx ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: ry = WIDTH'($urandom);
      endcase
      run_op(i[0], rx, ry);
    end

    // both requesters held from reset: strict alternation
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    req0 = 1'b1; x0 = 8'hAA; y0 = 8'hAA;
    req1 = 1'b1; x1 = 8'h55; y1 = 8'h54;
    for (int k = 0; k < 4; k++) begin
      e.owner = k[0]; e.r = ~k[0]; e.req_cyc = 0; e.lat = 0; e.lat_valid = 1'b0;
      sb.push_back(e);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    exp_g = 1'b0;
    for (int i = 0; i < 100 && dones < 4; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        check("tie_gnt_onehot", gnt0 ^ gnt1, 1);
        check("tie_gnt_order", gnt1, exp_g);
        exp_g = ~exp_g;
      end
      if (done) dones++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("tie_dones", dones, 4);
    repeat (4) @(negedge clk);
    check("tie_idle", busy, 0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
